// File: rtl/pipeline_controller.sv
// Pipeline controller: run/step/halt sequencing, load-use hazard stall,
// branch/jump flush, and free-running activity counters.
module pipeline_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_halt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        branch_sel,
  input  logic        jump_sel,
  input  logic        dbg_start,
  input  logic        dbg_step,
  input  logic        dbg_halt_req,
  input  logic        dbg_mode,
  output logic        pipe_en,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        mux_ctrl_signal_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] cycle_count,
  output logic [15:0] stall_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_STEP_WAIT = 3'd2,
    S_STEP_EXEC = 3'd3,
    S_DRAIN     = 3'd4,
    S_HALTED    = 3'd5
  } state_t;

  state_t      r_state, w_next;
  logic [1:0]  r_drain_cnt;
  logic [31:0] r_cycle_count;
  logic [15:0] r_stall_count;
  logic        w_load_use, w_issue, w_halt_go;

  // Load in EX feeding a source of the ID instruction; r0 never hazards.
  assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  // States in which a new instruction may issue from ID.
  assign w_issue    = (r_state == S_RUN) || (r_state == S_STEP_EXEC);
  // A halt is only honoured once any load-use stall has cleared.
  assign w_halt_go  = w_issue && !w_load_use && (id_halt || dbg_halt_req);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and enable decode.
  always_comb begin
    w_next              = r_state;
    pipe_en             = 1'b0;
    pc_write            = 1'b0;
    ifid_write          = 1'b0;
    ifid_flush          = 1'b0;
    mux_ctrl_signal_sel = 1'b0;
    if (w_issue) begin
      pipe_en = 1'b1;
      if (!w_load_use) begin
        pc_write            = 1'b1;
        ifid_write          = 1'b1;
        ifid_flush          = branch_sel || jump_sel;
        // The halting instruction is replaced by a bubble in EX.
        mux_ctrl_signal_sel = !w_halt_go;
      end
    end
    case (r_state)
      S_IDLE:      if (dbg_start) w_next = dbg_mode ? S_STEP_WAIT : S_RUN;
      S_RUN:       if (w_halt_go) w_next = S_DRAIN;
                   else if (dbg_mode) w_next = S_STEP_WAIT;
      S_STEP_WAIT: if (!dbg_mode) w_next = S_RUN;
                   else if (dbg_step) w_next = S_STEP_EXEC;
      S_STEP_EXEC: w_next = w_halt_go ? S_DRAIN : S_STEP_WAIT;
      S_DRAIN: begin
        pipe_en    = 1'b1;
        ifid_flush = 1'b1;
        if (r_drain_cnt == 2'd2) w_next = S_HALTED;
      end
      S_HALTED:    w_next = S_HALTED;
      default:     w_next = S_IDLE;
    endcase
  end

  // Drain counter: tracks EX, MEM, WB being emptied after a halt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   r_drain_cnt <= 2'd0;
    else if (r_state == S_DRAIN)  r_drain_cnt <= r_drain_cnt + 2'd1;
    else                          r_drain_cnt <= 2'd0;
  end

  // Saturating activity and stall counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle_count <= 32'd0;
      r_stall_count <= 16'd0;
    end else begin
      if (pipe_en && (r_cycle_count != 32'hFFFF_FFFF))
        r_cycle_count <= r_cycle_count + 32'd1;
      if (w_issue && w_load_use && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign state       = r_state;
  assign halted      = (r_state == S_HALTED);
  assign cycle_count = r_cycle_count;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: hazard vector table in RUN plus hand
// sequences for halt/drain, reset abort and single-step.
module tb_pipeline_controller;

  logic        clock, reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_halt, ex_mem_read, branch_sel, jump_sel;
  logic        dbg_start, dbg_step, dbg_halt_req, dbg_mode;
  logic        pipe_en, pc_write, ifid_write, ifid_flush, mux_ctrl_signal_sel;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] cycle_count;
  logic [15:0] stall_count;

  pipeline_controller dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_halt(id_halt), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .branch_sel(branch_sel), .jump_sel(jump_sel),
    .dbg_start(dbg_start), .dbg_step(dbg_step), .dbg_halt_req(dbg_halt_req),
    .dbg_mode(dbg_mode), .pipe_en(pipe_en), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .mux_ctrl_signal_sel(mux_ctrl_signal_sel), .state(state), .halted(halted),
    .cycle_count(cycle_count), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic mr; logic [4:0] ert, rs, rt; logic ut, br, jp, hlt;
    logic pcw, ifw, fl, sel, stall;
  } vec_t;

  typedef struct {
    logic [2:0] st; logic pe, pcw, ifw, fl, sel;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   n_chk = 0, n_err = 0;
  int   exp_cyc = 0, exp_stl = 0;
  logic [31:0] frozen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic mr, input logic [4:0] ert, rs, rt,
                              input logic ut, br, jp, hlt, pcw, ifw, fl, sel, stall);
    vec_t v;
    v.mr = mr; v.ert = ert; v.rs = rs; v.rt = rt; v.ut = ut; v.br = br;
    v.jp = jp; v.hlt = hlt; v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.sel = sel;
    v.stall = stall;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ex_mem_read = v.mr; ex_rt = v.ert; id_rs = v.rs; id_rt = v.rt;
    id_uses_rt = v.ut; branch_sel = v.br; jump_sel = v.jp; id_halt = v.hlt;
  endtask

  task automatic push(input logic [2:0] st, input logic pe, pcw, ifw, fl, sel);
    exp_t e;
    e.st = st; e.pe = pe; e.pcw = pcw; e.ifw = ifw; e.fl = fl; e.sel = sel;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    chk({nm, ".state"}, {29'd0, state}, {29'd0, e.st});
    chk({nm, ".pipe_en"}, {31'd0, pipe_en}, {31'd0, e.pe});
    chk({nm, ".pc_write"}, {31'd0, pc_write}, {31'd0, e.pcw});
    chk({nm, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, e.ifw});
    chk({nm, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, e.fl});
    chk({nm, ".sel"}, {31'd0, mux_ctrl_signal_sel}, {31'd0, e.sel});
  endtask

  initial begin
    //          mr  ert    rs     rt    ut br jp hl  pcw ifw fl sel stall
    vecs[0] = mk(0, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0,  1, 1, 0, 1, 0); // clean
    vecs[1] = mk(1, 5'd5,  5'd5,  5'd0, 0, 1, 0, 0,  0, 0, 0, 0, 1); // rs hazard beats branch
    vecs[2] = mk(0, 5'd5,  5'd5,  5'd0, 0, 1, 0, 0,  1, 1, 1, 1, 0); // stall cleared, flush
    vecs[3] = mk(1, 5'd0,  5'd0,  5'd0, 0, 0, 0, 0,  1, 1, 0, 1, 0); // r0 never hazards
    vecs[4] = mk(1, 5'd7,  5'd3,  5'd7, 0, 0, 0, 0,  1, 1, 0, 1, 0); // rt not used
    vecs[5] = mk(1, 5'd7,  5'd3,  5'd7, 1, 0, 0, 0,  0, 0, 0, 0, 1); // rt hazard
    vecs[6] = mk(0, 5'd0,  5'd0,  5'd0, 0, 0, 1, 0,  1, 1, 1, 1, 0); // jump flush
    vecs[7] = mk(1, 5'd9,  5'd10, 5'd9, 1, 0, 1, 0,  0, 0, 0, 0, 1); // hazard beats jump
    vecs[8] = mk(1, 5'd4,  5'd4,  5'd0, 0, 0, 0, 1,  0, 0, 0, 0, 1); // hazard defers halt
    vecs[9] = mk(1, 5'd31, 5'd30, 5'd31,0, 0, 0, 0,  1, 1, 0, 1, 0); // rt match, unused

    reset = 1'b0;
    id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 0; id_halt = 0;
    ex_mem_read = 0; branch_sel = 0; jump_sel = 0;
    dbg_start = 0; dbg_step = 0; dbg_halt_req = 0; dbg_mode = 0;

    // Reset state
    #3;
    chk("rst.state", {29'd0, state}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    chk("rst.cycle", cycle_count, 32'd0);
    chk("rst.stall", {16'd0, stall_count}, 32'd0);
    chk("rst.pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("rst.pc_write", {31'd0, pc_write}, 32'd0);
    chk("rst.ifid_write", {31'd0, ifid_write}, 32'd0);
    chk("rst.flush", {31'd0, ifid_flush}, 32'd0);
    chk("rst.sel", {31'd0, mux_ctrl_signal_sel}, 32'd0);

    // Released: waits in IDLE for dbg_start
    @(negedge clock); reset = 1'b1;
    @(negedge clock); @(negedge clock); #2;
    chk("idle.state", {29'd0, state}, 32'd0);
    chk("idle.pipe_en", {31'd0, pipe_en}, 32'd0);

    // Start in continuous mode
    @(negedge clock); dbg_start = 1; #2;
    chk("start.state0", {29'd0, state}, 32'd0);
    @(negedge clock); dbg_start = 0;
    push(3'd1, 1, 1, 1, 0, 1); #2;
    pop_cmp("run0");
    chk("run0.cycle", cycle_count, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock); #2;
      chk("run.cycle", cycle_count, k);
    end

    // Hazard table, one vector per RUN cycle
    exp_cyc = 4; exp_stl = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      push(3'd1, 1, vecs[i].pcw, vecs[i].ifw, vecs[i].fl, vecs[i].sel);
      #2;
      pop_cmp($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.cycle", i), cycle_count, exp_cyc);
      chk($sformatf("vec%0d.stall", i), {16'd0, stall_count}, exp_stl);
      exp_cyc++;
      if (vecs[i].stall) exp_stl++;
    end
    @(negedge clock);
    drive(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); #2;
    chk("tbl.cycle", cycle_count, exp_cyc);
    chk("tbl.stall", {16'd0, stall_count}, exp_stl);
    exp_cyc++;

    // HALT in RUN: bubble, then three DRAIN cycles, then HALTED
    @(negedge clock); id_halt = 1;
    push(3'd1, 1, 1, 1, 0, 0); #2;
    pop_cmp("halt");
    exp_cyc++;
    @(negedge clock); id_halt = 0;
    dbg_start = 1; dbg_mode = 1; dbg_step = 1;   // must all be ignored
    for (int d = 0; d < 3; d++) begin
      if (d > 0) @(negedge clock);
      push(3'd4, 1, 0, 0, 1, 0); #2;
      pop_cmp($sformatf("drain%0d", d));
      exp_cyc++;
    end
    @(negedge clock); #2;
    chk("hlt.state", {29'd0, state}, 32'd5);
    chk("hlt.halted", {31'd0, halted}, 32'd1);
    chk("hlt.pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("hlt.cycle", cycle_count, exp_cyc);
    frozen = exp_cyc;
    @(negedge clock); @(negedge clock); #2;
    chk("hlt.state_hold", {29'd0, state}, 32'd5);
    chk("hlt.cycle_frozen", cycle_count, frozen);
    dbg_start = 0; dbg_mode = 0; dbg_step = 0;

    // Async reset out of HALTED, away from any clock edge
    @(negedge clock); #2; reset = 0; #1;
    chk("rsth.state", {29'd0, state}, 32'd0);
    chk("rsth.halted", {31'd0, halted}, 32'd0);
    chk("rsth.cycle", cycle_count, 32'd0);

    // Reset during DRAIN (entered via dbg_halt_req)
    @(negedge clock); reset = 1; dbg_start = 1;
    @(negedge clock); dbg_start = 0; dbg_halt_req = 1; #2;
    chk("dhr.state", {29'd0, state}, 32'd1);
    chk("dhr.sel", {31'd0, mux_ctrl_signal_sel}, 32'd0);
    @(negedge clock); dbg_halt_req = 0; #2;
    chk("dhr.drain", {29'd0, state}, 32'd4);
    @(negedge clock); #2; reset = 0; #1;
    chk("rstd.state", {29'd0, state}, 32'd0);
    chk("rstd.halted", {31'd0, halted}, 32'd0);
    chk("rstd.cycle", cycle_count, 32'd0);
    chk("rstd.stall", {16'd0, stall_count}, 32'd0);
    chk("rstd.pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("rstd.flush", {31'd0, ifid_flush}, 32'd0);

    // Single-step: start+step together lands in STEP_WAIT, step ignored
    @(negedge clock); reset = 1; dbg_mode = 1; dbg_start = 1; dbg_step = 1;
    @(negedge clock); dbg_start = 0; dbg_step = 0; #2;
    chk("step.wait", {29'd0, state}, 32'd2);
    chk("step.wait_pe", {31'd0, pipe_en}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clock); dbg_step = 1; #2;
      chk("step.pre", {29'd0, state}, 32'd2);
      @(negedge clock); dbg_step = 0; #2;
      chk("step.exec", {29'd0, state}, 32'd3);
      chk("step.exec_pe", {31'd0, pipe_en}, 32'd1);
      @(negedge clock); #2;
      chk("step.back", {29'd0, state}, 32'd2);
      @(negedge clock); #2;
      chk("step.idle_pe", {31'd0, pipe_en}, 32'd0);
    end
    chk("step.cycle", cycle_count, 32'd3);

    // Leaving single-step returns to RUN
    @(negedge clock); dbg_mode = 0; #2;
    chk("mode.wait", {29'd0, state}, 32'd2);
    @(negedge clock); #2;
    chk("mode.run", {29'd0, state}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
